ram_port_arbiter: RTL and testbench

Shares one single-port synchronous RAM between two requesters: requester 0 is the host load/readback port, requester 1 is the selection-sort engine datapath. Each cycle it grants at most one access. Arbitration is round-robin. A requester can lock the port for back-to-back atomic sequences such as read-compare-swap. Read data is returned to the issuing requester with a tagged valid after the RAM read latency.

---
 rtl/ram_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin sharing of one single-port RAM between two
// requesters, with port locking and tagged read-data return.
// Build option: define ARB_STARVE_CNT_EN to add per-requester starvation
// counters that force-release a lock held against a starving requester.
module ram_port_arbiter #(
    parameter int SIZE_ADDR    = 8,
    parameter int SIZE_DATA    = 8,
    parameter int RD_LATENCY   = 1,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_req0,
    input  logic                 i_req1,
    input  logic                 i_we0,
    input  logic                 i_we1,
    input  logic                 i_lock0,
    input  logic                 i_lock1,
    input  logic [SIZE_ADDR-1:0] i_addr0,
    input  logic [SIZE_ADDR-1:0] i_addr1,
    input  logic [SIZE_DATA-1:0] i_wdata0,
    input  logic [SIZE_DATA-1:0] i_wdata1,
    output logic                 o_gnt0,
    output logic                 o_gnt1,
    output logic                 o_rvalid0,
    output logic                 o_rvalid1,
    output logic [SIZE_DATA-1:0] o_rdata0,
    output logic [SIZE_DATA-1:0] o_rdata1,
    output logic                 o_rd_en,
    output logic                 o_wr_en,
    output logic [SIZE_ADDR-1:0] o_addr,
    output logic [SIZE_DATA-1:0] o_wdata,
    input  logic [SIZE_DATA-1:0] i_rdata,
    output logic [1:0]           o_starve
);

    if (RD_LATENCY < 1 || RD_LATENCY > 4 ||
        STARVE_LIMIT < 2 || STARVE_LIMIT > 255) begin : g_bad_param
        $error("ram_port_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        LK_NONE = 2'd0,
        LK_0    = 2'd1,
        LK_1    = 2'd2
    } lock_e;

    typedef struct packed {
        logic vld;
        logic id;
    } rtn_t;

    lock_e                  lock_q, lock_d;
    logic                   ptr_q, ptr_d;
    logic                   gnt0, gnt1;
    logic [1:0]             starve;
    rtn_t [RD_LATENCY-1:0]  pipe_q;

`ifdef ARB_STARVE_CNT_EN
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] cnt0_q, cnt0_d;
    logic [7:0] cnt1_q, cnt1_d;

    // Count cycles spent requesting without a grant, saturating at 255.
    always_comb begin
        cnt0_d = 8'd0;
        cnt1_d = 8'd0;
        if (i_req0 && !gnt0)
            cnt0_d = (cnt0_q == 8'hFF) ? cnt0_q : cnt0_q + 8'd1;
        if (i_req1 && !gnt1)
            cnt1_d = (cnt1_q == 8'hFF) ? cnt1_q : cnt1_q + 8'd1;
    end

    // Starvation counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt0_q <= 8'd0;
            cnt1_q <= 8'd0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign starve = {cnt1_q >= LIMIT, cnt0_q >= LIMIT};
`else
    assign starve = 2'b00;
`endif

    // Grant: lock owner only, else lone requester, else the pointer's pick.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (i_rst_n) begin
            unique case (lock_q)
                LK_0:    gnt0 = i_req0;
                LK_1:    gnt1 = i_req1;
                default: begin
                    if (i_req0 && i_req1) begin
                        gnt0 = ~ptr_q;
                        gnt1 = ptr_q;
                    end else begin
                        gnt0 = i_req0;
                        gnt1 = i_req1;
                    end
                end
            endcase
        end
    end

    // Next pointer and lock owner; a starving peer breaks the lock.
    always_comb begin
        lock_d = lock_q;
        ptr_d  = ptr_q;
        if (gnt0)
            ptr_d = 1'b1;
        else if (gnt1)
            ptr_d = 1'b0;
        unique case (lock_q)
            LK_0: begin
                if (!i_req0 || (gnt0 && !i_lock0) || starve[1])
                    lock_d = LK_NONE;
            end
            LK_1: begin
                if (!i_req1 || (gnt1 && !i_lock1) || starve[0])
                    lock_d = LK_NONE;
            end
            default: begin
                if (gnt0 && i_lock0)
                    lock_d = LK_0;
                else if (gnt1 && i_lock1)
                    lock_d = LK_1;
                else
                    lock_d = LK_NONE;
            end
        endcase
    end

    // Lock owner and round-robin pointer registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lock_q <= LK_NONE;
            ptr_q  <= 1'b0;
        end else begin
            lock_q <= lock_d;
            ptr_q  <= ptr_d;
        end
    end

    // Read-return tag pipeline, aligned with the RAM read latency.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0].vld <= o_rd_en;
            pipe_q[0].id  <= gnt1;
            for (int i = 1; i < RD_LATENCY; i++)
                pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign o_gnt0    = gnt0;
    assign o_gnt1    = gnt1;
    assign o_rd_en   = (gnt0 & ~i_we0) | (gnt1 & ~i_we1);
    assign o_wr_en   = (gnt0 & i_we0) | (gnt1 & i_we1);
    assign o_addr    = gnt0 ? i_addr0 : (gnt1 ? i_addr1 : '0);
    assign o_wdata   = gnt0 ? i_wdata0 : (gnt1 ? i_wdata1 : '0);
    assign o_rvalid0 = pipe_q[RD_LATENCY-1].vld & ~pipe_q[RD_LATENCY-1].id;
    assign o_rvalid1 = pipe_q[RD_LATENCY-1].vld & pipe_q[RD_LATENCY-1].id;
    assign o_rdata0  = i_rst_n ? i_rdata : '0;
    assign o_rdata1  = i_rst_n ? i_rdata : '0;
    assign o_starve  = starve;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: drives ram_port_arbiter with a RAM model and checks
// every cycle against a queue-based model of the arbitration rules.
module tb_ram_port_arbiter;

    localparam int LAT   = 3;
    localparam int LIMIT = 4;
`ifdef ARB_STARVE_CNT_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    typedef struct {
        int         due;
        int         id;
        logic [7:0] data;
    } ret_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req [2];
    logic       we  [2];
    logic       lk  [2];
    logic [7:0] ad  [2];
    logic [7:0] wd  [2];
    logic       gnt0, gnt1, rvalid0, rvalid1, rd_en, wr_en;
    logic [7:0] rdata0, rdata1, addr_o, wdata_o, rdata;
    logic [1:0] starve;
    logic [23:0] obs;

    logic       clear_ram;
    logic [7:0] ram   [256];
    logic [7:0] rpipe [LAT];

    int         checks = 0;
    int         errors = 0;

    int         cyc = 0;
    int         m_ptr, m_owner, m_g;
    int         m_cnt [2];
    bit         st [2];
    logic [7:0] shadow [256];
    ret_t       rq [$];
    logic       e_rv [2];
    logic [7:0] e_rdata;
    logic [23:0] exp_v;

    always #5 clk = ~clk;

    ram_port_arbiter #(
        .SIZE_ADDR(8), .SIZE_DATA(8),
        .RD_LATENCY(LAT), .STARVE_LIMIT(LIMIT)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0(req[0]), .i_req1(req[1]),
        .i_we0(we[0]), .i_we1(we[1]),
        .i_lock0(lk[0]), .i_lock1(lk[1]),
        .i_addr0(ad[0]), .i_addr1(ad[1]),
        .i_wdata0(wd[0]), .i_wdata1(wd[1]),
        .o_gnt0(gnt0), .o_gnt1(gnt1),
        .o_rvalid0(rvalid0), .o_rvalid1(rvalid1),
        .o_rdata0(rdata0), .o_rdata1(rdata1),
        .o_rd_en(rd_en), .o_wr_en(wr_en),
        .o_addr(addr_o), .o_wdata(wdata_o),
        .i_rdata(rdata), .o_starve(starve)
    );

    assign obs = {gnt0, gnt1, rd_en, wr_en, addr_o, wdata_o,
                  rvalid0, rvalid1, starve};

    // Single-port RAM with LAT cycles of read latency.
    always @(posedge clk) begin
        if (clear_ram) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
        end else if (wr_en) begin
            ram[addr_o] <= wdata_o;
        end
        rpipe[0] <= ram[addr_o];
        for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign rdata = rpipe[LAT-1];

    task automatic idle();
        for (int n = 0; n < 2; n++) begin
            req[n] = 1'b0; we[n] = 1'b0; lk[n] = 1'b0;
            ad[n] = 8'h00; wd[n] = 8'h00;
        end
    endtask

    task automatic model_eval();
        logic e_rd, e_wr;
        logic [7:0] e_a, e_d;
        if (!rst_n) begin
            m_ptr = 0; m_owner = -1;
            m_cnt[0] = 0; m_cnt[1] = 0;
            rq.delete();
        end
        for (int n = 0; n < 2; n++)
            st[n] = STARVE_EN && (m_cnt[n] >= LIMIT);
        m_g = -1;
        if (rst_n) begin
            if (m_owner >= 0) begin
                if (req[m_owner]) m_g = m_owner;
            end else if (req[0] && req[1]) m_g = m_ptr;
            else if (req[0]) m_g = 0;
            else if (req[1]) m_g = 1;
        end
        e_rd = 1'b0; e_wr = 1'b0; e_a = 8'h00; e_d = 8'h00;
        if (m_g >= 0) begin
            e_rd = !we[m_g]; e_wr = we[m_g];
            e_a = ad[m_g]; e_d = wd[m_g];
        end
        e_rv[0] = 1'b0; e_rv[1] = 1'b0; e_rdata = 8'h00;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            e_rv[rq[0].id] = 1'b1;
            e_rdata = rq[0].data;
        end
        exp_v = {m_g == 0, m_g == 1, e_rd, e_wr, e_a, e_d,
                 e_rv[0], e_rv[1], st[1], st[0]};
    endtask

    task automatic model_commit();
        int nxt;
        if (rst_n) begin
            if (rq.size() > 0 && rq[0].due == cyc) rq.delete(0);
            if (m_g >= 0) begin
                if (we[m_g]) shadow[ad[m_g]] = wd[m_g];
                else rq.push_back('{cyc + LAT, m_g, shadow[ad[m_g]]});
                m_ptr = 1 - m_g;
            end
            nxt = m_owner;
            if (m_owner < 0) begin
                if (m_g >= 0 && lk[m_g]) nxt = m_g;
            end else if (!req[m_owner] || !lk[m_owner] || st[1 - m_owner]) begin
                nxt = -1;
            end
            m_owner = nxt;
            for (int n = 0; n < 2; n++) begin
                if (req[n] && m_g != n)
                    m_cnt[n] = (m_cnt[n] < 255) ? m_cnt[n] + 1 : 255;
                else
                    m_cnt[n] = 0;
            end
        end
        cyc++;
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic adv();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int n = 0; n < 2; n++) begin
                req[n] = 1'($urandom); we[n] = 1'($urandom);
                lk[n] = 1'($urandom); ad[n] = 8'($urandom);
                wd[n] = 8'($urandom);
            end
            settle();
            checks++;
            if ({obs, rdata0, rdata1} !== 40'h0) begin
                errors++;
                $display("FAIL reset_outputs k=%0d got=%h want=0", k, {obs, rdata0, rdata1});
            end
            adv();
        end
        idle();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int seen;
        seen = -1;
        idle();
        req[0] = 1'b1; we[0] = 1'b1; ad[0] = 8'h05; wd[0] = 8'hA3;
        for (int k = 0; k < LAT + 3; k++) begin
            settle();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL single cyc=%0d got=%h want=%h", cyc, obs, exp_v);
            end
            if (k < 2) begin
                checks++;
                if ({gnt0, wr_en, rd_en} !== ((k == 0) ? 3'b110 : 3'b101)) begin
                    errors++;
                    $display("FAIL single_cmd k=%0d got=%b", k, {gnt0, wr_en, rd_en});
                end
            end
            if (rvalid0) begin
                seen = k;
                checks++;
                if (rdata0 !== 8'hA3) begin
                    errors++;
                    $display("FAIL single_rdata got=%h want=a3", rdata0);
                end
            end
            adv();
            if (k == 0) we[0] = 1'b0;
            if (k == 1) req[0] = 1'b0;
        end
        checks++;
        if (seen !== LAT + 1) begin
            errors++;
            $display("FAIL single_latency got=%0d want=%0d", seen, LAT + 1);
        end
    endtask

    task automatic test_alternate();
        idle();
        rst_n = 1'b0; settle(); adv(); rst_n = 1'b1;
        req[0] = 1'b1; req[1] = 1'b1;
        ad[0] = 8'($urandom_range(0, 15)); ad[1] = 8'($urandom_range(0, 15));
        for (int k = 0; k < 8 + LAT + 1; k++) begin
            if (k == 8) begin req[0] = 1'b0; req[1] = 1'b0; end
            settle();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL alternate cyc=%0d got=%h want=%h", cyc, obs, exp_v);
            end
            if (e_rv[0] || e_rv[1]) begin
                checks++;
                if ((e_rv[0] ? rdata0 : rdata1) !== e_rdata) begin
                    errors++;
                    $display("FAIL alternate_rdata cyc=%0d want=%h", cyc, e_rdata);
                end
            end
            if (k < 8) begin
                checks++;
                if ({gnt0, gnt1} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL alternate_order k=%0d got=%b", k, {gnt0, gnt1});
                end
            end
            adv();
            if (m_g >= 0) ad[m_g] = 8'($urandom_range(0, 15));
        end
    endtask

    task automatic test_lock();
        idle();
        rst_n = 1'b0; settle(); adv(); rst_n = 1'b1;
        req[0] = 1'b1; ad[0] = 8'h20;
        settle(); adv();
        ad[0] = 8'h21;
        req[1] = 1'b1; lk[1] = 1'b1; ad[1] = 8'h10;
        for (int k = 0; k < 4 + LAT + 1; k++) begin
            settle();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL lock cyc=%0d got=%h want=%h", cyc, obs, exp_v);
            end
            if (e_rv[0] || e_rv[1]) begin
                checks++;
                if ((e_rv[0] ? rdata0 : rdata1) !== e_rdata) begin
                    errors++;
                    $display("FAIL lock_rdata cyc=%0d want=%h", cyc, e_rdata);
                end
            end
            if (k < 4) begin
                checks++;
                if (gnt0 !== (k == 3)) begin
                    errors++;
                    $display("FAIL lock_gnt0 k=%0d got=%b want=%b", k, gnt0, k == 3);
                end
            end
            adv();
            if (k == 0) ad[1] = 8'h11;
            if (k == 1) begin we[1] = 1'b1; ad[1] = 8'h10; wd[1] = 8'($urandom); lk[1] = 1'b0; end
            if (k == 2) begin we[1] = 1'b0; ad[1] = 8'h12; end
            if (k == 3) idle();
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d0, d1;
        int n1;
        d0 = 8'($urandom); d1 = 8'($urandom); n1 = 0;
        idle();
        req[0] = 1'b1; we[0] = 1'b1; ad[0] = 8'h00; wd[0] = d0;
        settle(); adv();
        ad[0] = 8'h01; wd[0] = d1;
        settle(); adv();
        idle();
        req[1] = 1'b1; ad[1] = 8'h00;
        for (int k = 0; k < LAT + 4; k++) begin
            settle();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL b2b cyc=%0d got=%h want=%h", cyc, obs, exp_v);
            end
            if (rvalid1) begin
                n1++;
                checks++;
                if (!((k == LAT && rdata1 === d0) || (k == LAT + 1 && rdata1 === d1))) begin
                    errors++;
                    $display("FAIL b2b_return k=%0d got=%h want=%h/%h", k, rdata1, d0, d1);
                end
            end
            adv();
            if (k == 0) ad[1] = 8'h01;
            if (k == 1) idle();
        end
        checks++;
        if (n1 !== 2) begin
            errors++;
            $display("FAIL b2b_count got=%0d want=2", n1);
        end
    endtask

    task automatic test_reset_mid();
        int nv;
        nv = 0;
        idle();
        req[1] = 1'b1; lk[1] = 1'b1; ad[1] = 8'($urandom_range(0, 15));
        settle(); adv();
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            settle();
            checks++;
            if (obs !== 24'h0) begin
                errors++;
                $display("FAIL mid_reset_out k=%0d got=%h want=0", k, obs);
            end
            adv();
        end
        rst_n = 1'b1;
        idle();
        for (int k = 0; k < LAT + 2; k++) begin
            settle();
            if (rvalid0 || rvalid1) nv++;
            adv();
        end
        checks++;
        if (nv !== 0) begin
            errors++;
            $display("FAIL mid_reset_rvalid got=%0d want=0", nv);
        end
        req[0] = 1'b1; req[1] = 1'b1;
        settle();
        checks++;
        if ({gnt0, gnt1} !== 2'b10 || obs !== exp_v) begin
            errors++;
            $display("FAIL mid_reset_ptr got=%h want=%h", obs, exp_v);
        end
        adv();
        idle();
        for (int k = 0; k < LAT + 1; k++) begin settle(); adv(); end
    endtask

    task automatic test_starve();
        int fs, fg;
        fs = -1; fg = -1;
        idle();
        rst_n = 1'b0; settle(); adv(); rst_n = 1'b1;
        req[1] = 1'b1; lk[1] = 1'b1; ad[1] = 8'($urandom_range(0, 15));
        settle(); adv();
        req[0] = 1'b1; ad[0] = 8'h30;
        for (int k = 0; k < 12; k++) begin
            settle();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL starve cyc=%0d got=%h want=%h", cyc, obs, exp_v);
            end
            if (starve[0] && fs < 0) fs = k;
            if (gnt0 && fg < 0) fg = k;
            adv();
            if (m_g == 1) ad[1] = 8'($urandom_range(0, 15));
            if (m_g == 0) req[0] = 1'b0;
        end
        checks++;
`ifdef ARB_STARVE_CNT_EN
        if (fs !== LIMIT || fg < fs || fg > fs + 2) begin
            errors++;
            $display("FAIL starve_break starve_at=%0d gnt0_at=%0d want=%0d..%0d", fs, fg, LIMIT, LIMIT + 2);
        end
`else
        if (fs !== -1 || fg !== -1) begin
            errors++;
            $display("FAIL starve_off starve_at=%0d gnt0_at=%0d want=-1", fs, fg);
        end
`endif
        idle();
        for (int k = 0; k < LAT + 1; k++) begin settle(); adv(); end
    endtask

    task automatic test_random();
        bit pend [2];
        idle();
        rst_n = 1'b0; settle(); adv(); rst_n = 1'b1;
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int k = 0; k < 400 + LAT + 1; k++) begin
            for (int n = 0; n < 2; n++) begin
                if (!pend[n]) begin
                    if (k < 400 && $urandom_range(0, 3) != 0) begin
                        pend[n] = 1'b1;
                        req[n] = 1'b1;
                        we[n] = 1'($urandom);
                        lk[n] = ($urandom_range(0, 3) == 0);
                        ad[n] = 8'($urandom_range(0, 15));
                        wd[n] = 8'($urandom);
                    end else begin
                        req[n] = 1'b0; lk[n] = 1'b0;
                    end
                end
            end
            settle();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs, exp_v);
            end
            if (e_rv[0] || e_rv[1]) begin
                checks++;
                if ((e_rv[0] ? rdata0 : rdata1) !== e_rdata) begin
                    errors++;
                    $display("FAIL random_rdata cyc=%0d got=%h/%h want=%h", cyc, rdata0, rdata1, e_rdata);
                end
            end
            if (m_g >= 0) pend[m_g] = 1'b0;
            adv();
        end
        idle();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = 8'h00;
        rst_n = 1'b0;
        clear_ram = 1'b1;
        idle();
        @(negedge clk);
        clear_ram = 1'b0;
        test_reset();
        test_single();
        test_alternate();
        test_lock();
        test_back_to_back();
        test_reset_mid();
        test_starve();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
